// File: rtl/vga_scan_gen_pkg.sv
// Shared display package: default 640x480 timing, sync polarity and the
// control-bundle type carried through the sync/blank delay line.
package vga_scan_gen_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   localparam logic SYNC_ACTIVE = 1'b0;
   localparam logic SYNC_IDLE   = 1'b1;

   localparam int POS_W = 10;
   typedef logic [POS_W-1:0] pos_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } vga_ctl_t;

   localparam vga_ctl_t CTL_IDLE = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, video_on: 1'b0};

   function automatic logic in_range(input pos_t p, input pos_t lo, input pos_t hi);
      return (p >= lo) && (p <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated delay line for the sync/blank bundle; depth 0 is a wire
// that still forces the idle value while reset is held.
module vga_sync_delay #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic w_unused;
         assign w_unused = i_clk ^ i_en;
         assign o_q      = i_rst_n ? i_d : RST_VAL;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_pipe <= {DEPTH{RST_VAL}};
            end else if (i_en) begin
               r_pipe[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign o_q = r_pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan counters with sync/blank generation; sync and video_on are
// delayed PIPE_STAGES pixel ticks, the position counters never are.
module vga_scan_gen
   import vga_scan_gen_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter int PIPE_STAGES = 1
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_en,
   output logic [9:0] pixel_column,
   output logic [9:0] pixel_row,
   output logic       horiz_sync,
   output logic       vert_sync,
   output logic       video_on,
   output logic       frame_start
);

   localparam pos_t H_VIS    = pos_t'(H_ACTIVE);
   localparam pos_t V_VIS    = pos_t'(V_ACTIVE);
   localparam pos_t H_LAST   = pos_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam pos_t V_LAST   = pos_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam pos_t HS_FIRST = pos_t'(H_ACTIVE + H_FRONT);
   localparam pos_t HS_LAST  = pos_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam pos_t VS_FIRST = pos_t'(V_ACTIVE + V_FRONT);
   localparam pos_t VS_LAST  = pos_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   pos_t     r_col;
   pos_t     r_row;
   logic     r_frame_start;
   logic     w_h_wrap;
   logic     w_v_wrap;
   vga_ctl_t w_ctl_raw;
   vga_ctl_t w_ctl_dly;

   assign w_h_wrap = (r_col == H_LAST);
   assign w_v_wrap = (r_row == V_LAST);

   // frame_start is a plain registered strobe, so it drops after one clock
   // even when the following clocks carry no pixel tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col         <= '0;
         r_row         <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= pix_en && w_h_wrap && w_v_wrap;
         if (pix_en) begin
            if (w_h_wrap) begin
               r_col <= '0;
               r_row <= w_v_wrap ? '0 : r_row + pos_t'(1);
            end else begin
               r_col <= r_col + pos_t'(1);
            end
         end
      end
   end

   always_comb begin
      w_ctl_raw          = CTL_IDLE;
      w_ctl_raw.hsync    = in_range(r_col, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : SYNC_IDLE;
      w_ctl_raw.vsync    = in_range(r_row, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : SYNC_IDLE;
      w_ctl_raw.video_on = (r_col < H_VIS) && (r_row < V_VIS);
   end

   vga_sync_delay #(
      .DEPTH   (PIPE_STAGES),
      .WIDTH   ($bits(vga_ctl_t)),
      .RST_VAL (CTL_IDLE)
   ) u_dly (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_en    (pix_en),
      .i_d     (w_ctl_raw),
      .o_q     (w_ctl_dly)
   );

   assign pixel_column = r_col;
   assign pixel_row    = r_row;
   assign horiz_sync   = w_ctl_dly.hsync;
   assign vert_sync    = w_ctl_dly.vsync;
   assign video_on     = w_ctl_dly.video_on;
   assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: default-timing scanner (no delay) plus a miniature-timing scanner
// (2-tick delay) sharing stimulus, checked every clock against a tick-count model.
module tb_vga_scan_gen;

   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic       hs;
      logic       vs;
      logic       de;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic pix_en;

   logic [9:0] b_col, b_row, s_col, s_row;
   logic       b_hs, b_vs, b_de, b_fs;
   logic       s_hs, s_vs, s_de, s_fs;

   int n = 0;
   logic fs_b_exp = 1'b0;
   logic fs_s_exp = 1'b0;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_scan_gen #(.PIPE_STAGES(0)) u_big (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
      .pixel_column(b_col), .pixel_row(b_row),
      .horiz_sync(b_hs), .vert_sync(b_vs), .video_on(b_de), .frame_start(b_fs));

   vga_scan_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .PIPE_STAGES(2)
   ) u_small (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
      .pixel_column(s_col), .pixel_row(s_row),
      .horiz_sync(s_hs), .vert_sync(s_vs), .video_on(s_de), .frame_start(s_fs));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs after n pixel ticks since reset, for a scanner of the given timing.
   function automatic exp_t model(input int tick, input bit rst,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input int ns);
      exp_t e;
      int ht, vt, m, c, r;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      e.col = 10'(tick % ht);
      e.row = 10'((tick / ht) % vt);
      if (rst || tick < ns) begin
         e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
      end else begin
         m = tick - ns;
         c = m % ht;
         r = (m / ht) % vt;
         e.hs = !(c >= ha + hf && c < ha + hf + hsw);
         e.vs = !(r >= va + vf && r < va + vf + vsw);
         e.de = (c < ha) && (r < va);
      end
      return e;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n        <= 0;
         fs_b_exp <= 1'b0;
         fs_s_exp <= 1'b0;
      end else begin
         fs_b_exp <= pix_en && ((n + 1) % 420000 == 0);
         fs_s_exp <= pix_en && ((n + 1) % 180 == 0);
         if (pix_en) n <= n + 1;
      end
   end

   always @(negedge clk) begin
      exp_t eb, es;
      eb = model(n, !reset_n, 640, 16, 96, 48, 480, 10, 2, 33, 0);
      es = model(n, !reset_n, 8, 2, 3, 2, 6, 1, 2, 3, 2);
      chk("big_col", b_col, eb.col);
      chk("big_row", b_row, eb.row);
      chk("big_hs",  b_hs,  eb.hs);
      chk("big_vs",  b_vs,  eb.vs);
      chk("big_de",  b_de,  eb.de);
      chk("big_fs",  b_fs,  fs_b_exp);
      chk("sm_col",  s_col, es.col);
      chk("sm_row",  s_row, es.row);
      chk("sm_hs",   s_hs,  es.hs);
      chk("sm_vs",   s_vs,  es.vs);
      chk("sm_de",   s_de,  es.de);
      chk("sm_fs",   s_fs,  fs_s_exp);
   end

   task automatic step(input logic en);
      pix_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bcol"}, b_col, 0);
      chk({tag, "_brow"}, b_row, 0);
      chk({tag, "_bhs"},  b_hs,  1);
      chk({tag, "_bvs"},  b_vs,  1);
      chk({tag, "_bde"},  b_de,  0);
      chk({tag, "_bfs"},  b_fs,  0);
      chk({tag, "_sde"},  s_de,  0);
      chk({tag, "_svs"},  s_vs,  1);
   endtask

   initial begin
      int hs_low, vs_low, de_hi, fs_cnt, fs_first;
      int last_bw, last_sf, bw_n, sf_n;
      logic [9:0] prev_bcol;

      reset_n = 1'b0;
      pix_en  = 1'b0;
      repeat (3) step(1);
      chk_reset_vals("rst");

      // continuous ticks from reset release
      reset_n  = 1'b1;
      hs_low   = 0; vs_low = 0; de_hi = 0; fs_cnt = 0; fs_first = -1;
      for (int t = 1; t <= 800; t++) begin
         step(1);
         if (t == 1)   chk("sm_de_t1", s_de, 0);
         if (t == 2)   chk("sm_de_t2", s_de, 1);
         if (t == 106) chk("sm_vs_t106", s_vs, 1);
         if (t == 107) chk("sm_vs_t107", s_vs, 0);
         if (t == 655) chk("hs_c655", b_hs, 1);
         if (t == 656) chk("hs_c656", b_hs, 0);
         if (t == 751) chk("hs_c751", b_hs, 0);
         if (t == 752) chk("hs_c752", b_hs, 1);
         if (t == 799) begin chk("col_799", b_col, 799); chk("row_799", b_row, 0); end
         if (t == 800) begin chk("col_wrap", b_col, 0); chk("row_wrap", b_row, 1); end
         if (!b_hs) hs_low++;
         if (t >= 180 && t < 360) begin
            if (!s_vs) vs_low++;
            if (s_de)  de_hi++;
         end
         if (s_fs) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = t;
         end
      end
      chk("hs_low_per_line", hs_low, 96);
      chk("vs_low_per_frame", vs_low, 30);
      chk("de_hi_per_frame", de_hi, 48);
      chk("fs_first_tick", fs_first, 180);
      chk("fs_count", fs_cnt, 4);

      // one tick every 4th clock
      prev_bcol = b_col;
      last_bw = -1; last_sf = -1; bw_n = 0; sf_n = 0;
      for (int c = 0; c < 8000; c++) begin
         step(c % 4 == 3);
         if (b_col == 0 && prev_bcol != 0) begin
            if (last_bw >= 0) begin chk("line_period", c - last_bw, 3200); bw_n++; end
            last_bw = c;
         end
         prev_bcol = b_col;
         if (s_fs) begin
            if (last_sf >= 0) begin chk("frame_period", c - last_sf, 720); sf_n++; end
            last_sf = c;
         end
      end
      chk("line_period_seen", bw_n, 1);
      chk("frame_period_seen", sf_n >= 5, 1);

      // random enables with occasional asynchronous resets
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 2999) == 0) begin
            reset_n = 1'b0;
            #1;
            chk_reset_vals("rnd_rst");
            step(1);
            reset_n = 1'b1;
         end
         step($urandom_range(0, 2) != 0);
      end

      // reset mid-frame, then restart without a frame_start pulse
      repeat (50) step(1);
      reset_n = 1'b0;
      #2;
      chk_reset_vals("mid_rst");
      step(1);
      reset_n = 1'b1;
      step(1);
      chk("restart_bcol", b_col, 1);
      chk("restart_brow", b_row, 0);
      chk("restart_scol", s_col, 1);
      chk("restart_srow", s_row, 0);
      fs_cnt = 0;
      for (int t = 2; t < 180; t++) begin
         step(1);
         if (s_fs) fs_cnt++;
      end
      chk("no_fs_after_rst", fs_cnt, 0);
      step(1);
      chk("fs_next_frame", s_fs, 1);
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48, horizontal porch and sync widths in pixels (line total 800).
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FRONT, 10; V_SYNC, 2; V_BACK, 33, vertical porch and sync widths in lines (frame total 525).
REQ-005 Parameter PIPE_STAGES, 1, delay (0..3 pixel ticks) applied to sync/blank outputs to match downstream icon/colorizer latency.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 pix_en  input  1  pixel-tick enable; state advances only on cycles where pix_en=1.
REQ-009 pixel_column  output  10  current horizontal scan position 0..799 (consumers use it as horz).
REQ-010 pixel_row  output  10  current vertical scan position 0..524 (consumers use it as vert).
REQ-011 horiz_sync  output  1  active-low horizontal sync, delayed PIPE_STAGES ticks.
REQ-012 vert_sync  output  1  active-low vertical sync, delayed PIPE_STAGES ticks.
REQ-013 video_on  output  1  high in the visible region, delayed PIPE_STAGES ticks.
REQ-014 frame_start  output  1  one-clock pulse when the scan enters (0,0).

Function
REQ-015 On a clk edge with pix_en=1, pixel_column SHALL increment by 1, wrapping 799->0.
REQ-016 When pixel_column wraps, pixel_row SHALL increment by 1 on the same edge, wrapping 524->0.
REQ-017 With pix_en=0, counters, pipeline registers and all outputs SHALL hold their values, except frame_start, which SHALL be 0.
REQ-018 Undelayed hsync SHALL be 0 iff 656 <= pixel_column <= 751, otherwise 1.
REQ-019 Undelayed vsync SHALL be 0 iff 490 <= pixel_row <= 491, otherwise 1.
REQ-020 Undelayed video_on SHALL be 1 iff pixel_column < 640 and pixel_row < 480.
REQ-021 Boundary positions SHALL be derived from parameters, not hard-coded literals.
REQ-022 With PIPE_STAGES=0, horiz_sync/vert_sync/video_on SHALL be combinational functions of the current counters.
REQ-023 With PIPE_STAGES=N>0, these outputs SHALL pass through an N-deep shift register that advances only on pix_en=1.
REQ-024 pixel_column and pixel_row SHALL never be delayed.
REQ-025 frame_start SHALL be 1 for exactly the clk cycle following the pix_en edge that moves the counters from (799,524) to (0,0).
REQ-026 Counter arithmetic SHALL be 10-bit unsigned; no position outside 0..799 / 0..524 SHALL ever be output.

Reset
REQ-027 While reset_n=0, pixel_column=0, pixel_row=0, horiz_sync=1, vert_sync=1, video_on=0 and frame_start=0, independent of clk.
REQ-028 Every pipeline stage SHALL reset to its inactive value (sync 1, video_on 0).
REQ-029 After reset_n deasserts mid-frame, scanning SHALL restart at (0,0) on the first pix_en edge without a frame_start pulse.

Structure
REQ-030 VGA timing parameter defaults and sync polarity constants SHALL live in the shared display package used by the icon and colorizer blocks.
REQ-031 The PIPE_STAGES delay line SHALL be one sub-module, vga_sync_delay, parameterized by depth and width (3 bits).

Verification
REQ-032 Deassert reset, pix_en=1 for 800 clks -> pixel_column wraps 799->0 and pixel_row becomes 1.
REQ-033 PIPE_STAGES=0, run to column 656 -> horiz_sync falls at column 656 and rises at 752; 96 low ticks per line.
REQ-034 PIPE_STAGES=2, full frame -> vert_sync is low for 1600 ticks starting 2 ticks after (0,490); video_on is high for exactly 307200 ticks.
REQ-035 pix_en=1 every 4th clk (100 MHz, /4) -> outputs hold between ticks; line period is 3200 clks; frame_start pulses every 1,680,000 clks.
REQ-036 Assert reset_n=0 at (300,200) -> outputs reach reset values immediately; after release, first tick gives (1,0) and frame_start stays 0 until the next full frame.
